// File: rtl/rf_pkg.sv
// rf_pkg: shared types and defaults for the parametrised register file.
// Revision: 1.0
`default_nettype none

package rf_pkg;

  localparam int RF_DATA_W  = 8;
  localparam int RF_REG_NUM = 8;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_IDLE  = 1'b1
  } rf_state_t;

  // One extra bit so the sweep counter can step past the last index without wrapping.
  function automatic int rf_ctr_w(input int reg_num);
    return $clog2(reg_num) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_param_if.sv
// reg_file_param_if: decode/writeback-facing bus of the register file.
// Revision: 1.0
`default_nettype none

interface reg_file_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              regWrite;
  logic [ADDR_W-1:0] Rs;
  logic [ADDR_W-1:0] Rd;
  logic [DATA_W-1:0] writeValue;
  logic              clearReq;
  logic [DATA_W-1:0] RsVal;
  logic [DATA_W-1:0] RdVal;
  logic              cmpZero;
  logic              cmpEq;
  logic              busy;

  modport master (
    output regWrite, Rs, Rd, writeValue, clearReq,
    input  RsVal, RdVal, cmpZero, cmpEq, busy
  );

  modport slave (
    input  regWrite, Rs, Rd, writeValue, clearReq,
    output RsVal, RdVal, cmpZero, cmpEq, busy
  );
endinterface

`default_nettype wire

// File: rtl/rf_sweep_ctr.sv
// rf_sweep_ctr: index counter for the clear sweep; o_done flags the last register.
// Revision: 1.0
`default_nettype none

module rf_sweep_ctr
  import rf_pkg::*;
#(
  parameter int REG_NUM = RF_REG_NUM,
  parameter int ADDR_W  = $clog2(REG_NUM)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_start,
  input  wire logic              i_en,
  output logic      [ADDR_W-1:0] o_idx,
  output logic                   o_done
);
  localparam int CTR_W = rf_ctr_w(REG_NUM);

  logic [CTR_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_start) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CTR_W'(1);
    end
  end

  assign o_idx  = r_cnt[ADDR_W-1:0];
  assign o_done = (r_cnt == CTR_W'(REG_NUM - 1));

endmodule

`default_nettype wire

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with clear sweep and branch compares.
// Optional macro RF_BYPASS_EN enables same-cycle write-through forwarding. Revision: 1.0
`default_nettype none

module reg_file_param
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int REG_NUM  = RF_REG_NUM,
  parameter int ADDR_W   = $clog2(REG_NUM),
  parameter bit ZERO_REG = 1'b0
) (
  input wire logic         CLK,
  input wire logic         Reset,
  reg_file_param_if.slave  bus
);
  rf_state_t         r_state;
  rf_state_t         w_state_nxt;
  logic [DATA_W-1:0] r_regs [REG_NUM];
  logic [ADDR_W-1:0] w_idx;
  logic              w_done;
  logic              w_busy;
  logic              w_wr_ok;
  logic              w_rs_zero;
  logic              w_rd_zero;
  logic              w_fwd_rs;
  logic              w_fwd_rd;
  logic [DATA_W-1:0] w_rs;
  logic [DATA_W-1:0] w_rd;

  rf_sweep_ctr #(
    .REG_NUM (REG_NUM),
    .ADDR_W  (ADDR_W)
  ) u_sweep (
    .clk     (CLK),
    .rst     (Reset),
    .i_start ((r_state == RF_IDLE) && bus.clearReq),
    .i_en    (r_state == RF_CLEAR),
    .o_idx   (w_idx),
    .o_done  (w_done)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= RF_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RF_CLEAR: if (w_done)       w_state_nxt = RF_IDLE;
      RF_IDLE:  if (bus.clearReq) w_state_nxt = RF_CLEAR;
      default:                    w_state_nxt = RF_CLEAR;
    endcase
  end

  // Reset is folded in combinationally so outputs are clean before the first edge.
  assign w_busy    = Reset || (r_state != RF_IDLE);
  assign w_rs_zero = ZERO_REG && (bus.Rs == '0);
  assign w_rd_zero = ZERO_REG && (bus.Rd == '0);
  assign w_wr_ok   = !w_busy && bus.regWrite && !w_rd_zero;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      if (r_state == RF_CLEAR) begin
        r_regs[w_idx] <= '0;
      end else if (w_wr_ok) begin
        r_regs[bus.Rd] <= bus.writeValue;
      end
    end
  end

`ifdef RF_BYPASS_EN
  assign w_fwd_rs = w_wr_ok && (bus.Rs == bus.Rd);
  assign w_fwd_rd = w_wr_ok;
`else
  assign w_fwd_rs = 1'b0;
  assign w_fwd_rd = 1'b0;
`endif

  always_comb begin
    w_rs = w_rs_zero ? '0 : r_regs[bus.Rs];
    w_rd = w_rd_zero ? '0 : r_regs[bus.Rd];
    if (w_fwd_rs) w_rs = bus.writeValue;
    if (w_fwd_rd) w_rd = bus.writeValue;
  end

  assign bus.RsVal   = w_busy ? '0 : w_rs;
  assign bus.RdVal   = w_busy ? '0 : w_rd;
  assign bus.cmpZero = (bus.RsVal == '0);
  assign bus.cmpEq   = (bus.RsVal == bus.RdVal);
  assign bus.busy    = w_busy;

endmodule

`default_nettype wire

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised successor to the core's 8x8 register file: configurable width and depth, plus a zero/equality compare pair for early branch resolution.
Adds a sequential clear engine: after reset, or on request, it zeroes one register per cycle and blocks writes while busy.
Sits between decode (addresses, compare to branch unit) and writeback (regWrite/writeValue).

Parameters:
DATA_W, 8, register width in bits
REG_NUM, 8, number of registers (power of two, >=2)
ADDR_W, $clog2(REG_NUM), address width
ZERO_REG, 0, 1 = register 0 hardwired to zero (reads 0, writes dropped)

Ports:
CLK  in  1  clock, all state updates on posedge
Reset  in  1  synchronous, active-high reset
regWrite  in  1  write enable for Rd
Rs  in  ADDR_W  read address A / compare source
Rd  in  ADDR_W  read address B and write target
writeValue  in  DATA_W  write data
clearReq  in  1  one-cycle pulse, start clear sweep
RsVal  out  DATA_W  contents of Rs (combinational)
RdVal  out  DATA_W  contents of Rd (combinational)
cmpZero  out  1  RsVal == 0
cmpEq  out  1  RsVal == RdVal
busy  out  1  clear sweep active, writes ignored

Behaviour:
- Clock CLK; reset Reset is synchronous, active-high.
- States: CLEAR, IDLE. Reset -> CLEAR with sweep counter = 0.
- While Reset is high: busy=1, RsVal=RdVal=0, cmpZero=1, cmpEq=1.
- CLEAR: each cycle writes 0 to registers[cnt], then cnt++. Exits to IDLE on the cycle cnt==REG_NUM-1 is written. A full sweep takes exactly REG_NUM cycles after Reset deasserts; busy drops on cycle REG_NUM+1.
- CLEAR outputs: busy=1, RsVal/RdVal masked to 0, cmpZero=1, cmpEq=1. regWrite and clearReq are ignored (the write is dropped, not queued).
- IDLE: a regWrite write lands in registers[Rd] at posedge. Reads are combinational from the array, so a written value is visible from the next cycle.
- clearReq in IDLE -> CLEAR with cnt=0, starting next cycle. If regWrite and clearReq are both high in IDLE, the write occurs and is then swept to 0.
- Reset mid-sweep restarts cnt at 0.
- Counter is ADDR_W+1 bits wide, with no wrap within a sweep.
- ZERO_REG=1: address 0 reads 0 on both ports; writes to 0 are dropped.
- Rs==Rd is legal: cmpEq=1 in IDLE.
- All outputs are defined (no X) from the first cycle Reset is high.

Optional Feature:
RF_BYPASS_EN
- Defined: in IDLE with regWrite=1, a read port whose address equals Rd returns writeValue in the same cycle (write-through forwarding). cmpZero and cmpEq use the forwarded values. No forwarding during CLEAR, or to register 0 when ZERO_REG=1.
- Undefined: reads return array contents only; new data is visible one cycle after the write.

Decomposition:
- Package rf_pkg: enum rf_state_t {RF_CLEAR, RF_IDLE}; function for the counter width; shared default constants RF_DATA_W=8, RF_REG_NUM=8.
- Sub-module rf_sweep_ctr: counter with start/restart inputs and done/index outputs, drives the clear FSM. Array, read muxes and compares stay in the top.

Test Plan:
- Reset high 2 cycles, then low -> busy=1 for exactly 8 cycles (defaults), all reads 0. regWrite during the sweep is dropped: R3 still reads 0 after busy falls.
- IDLE: write R5=0xA7 -> next cycle Rs=5 gives RsVal=0xA7, cmpZero=0. Set Rd=5 -> cmpEq=1; Rd=2 -> cmpEq=0.
- Write all 8 registers 0x11..0x88, pulse clearReq -> busy 8 cycles, then all reads 0. clearReq during busy does not extend the sweep.
- Reset asserted on sweep cycle 4 -> sweep restarts, busy lasts 8 more cycles after Reset falls.
- ZERO_REG=1, DATA_W=16, REG_NUM=16: write R0=0xBEEF -> R0 reads 0, cmpZero=1. Write R15=0xFFFF -> reads 0xFFFF.
- RF_BYPASS_EN: regWrite, Rd=Rs=4, writeValue=0 -> same cycle RsVal=0, cmpZero=1. Without the macro, RsVal keeps the old value until next cycle.
